// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: the sequencer state for the single-outstanding-request imem port.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    localparam int unsigned InstrBytes = 4;

endpackage : fetch_pkg

// File: rtl/pc_fetch.sv
// PC register and fetch sequencer: one imem request at a time, fetched word offered to decode.
// Latency: gnt at t, rvalid at t+1, instr_valid at t+2 (zero wait states); 1 instr per 3 cycles.
// Backpressure: instr held stable and no new request while instr_valid && !instr_ready.
module pc_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned          AddrWidth = 32,
    parameter int unsigned          DataWidth = 32,
    parameter logic [AddrWidth-1:0] ResetAddr = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AddrWidth-1:0] pc_in,
    input  logic                 flush,
    output logic [AddrWidth-1:0] pc,
    output logic [AddrWidth-1:0] pc_plus4,
    output logic                 imem_req,
    output logic [AddrWidth-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [DataWidth-1:0] imem_rdata,
    output logic                 instr_valid,
    output logic [DataWidth-1:0] instr,
    output logic [AddrWidth-1:0] instr_pc,
    input  logic                 instr_ready
);

    fetch_state_t         state_q, state_d;
    logic [AddrWidth-1:0] pc_q, pc_d;
    logic [DataWidth-1:0] instr_q, instr_d;
    logic [AddrWidth-1:0] instr_pc_q, instr_pc_d;
    logic                 instr_valid_q, instr_valid_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= REQ;
            pc_q          <= ResetAddr;
            instr_q       <= '0;
            instr_pc_q    <= ResetAddr;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        // A redirect always reloads the PC; the state column decides what happens to in-flight data.
        if (flush) begin
            pc_d = pc_in;
        end

        unique case (state_q)
            REQ: begin
                if (imem_gnt) begin
                    state_d = flush ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                    if (!flush) begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = VALID;
                    end
                end else if (flush) begin
                    state_d = DROP;
                end
            end
            VALID: begin
                if (flush || instr_ready) begin
                    pc_d          = pc_in;
                    instr_valid_d = 1'b0;
                    state_d       = REQ;
                end
            end
            DROP: begin
                // The stale response still has to drain even if another redirect lands with it.
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + AddrWidth'(InstrBytes);
    assign imem_addr   = pc_q;
    assign imem_req    = (state_q == REQ);
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

    a_no_stray_rvalid: assert property (
        @(posedge clk) disable iff (reset)
        !(imem_rvalid && (state_q == REQ || state_q == VALID))
    );

    a_hold_stable: assert property (
        @(posedge clk) disable iff (reset)
        (instr_valid && !instr_ready && !flush) |=>
            (instr_valid && $stable(instr) && $stable(instr_pc))
    );

endmodule : pc_fetch

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
PC register and instruction-fetch sequencer that sits directly downstream of pc_mux. It holds the architectural PC and issues one instruction-memory request at a time. It presents the fetched word to decode with a valid/ready handshake. It loads pc_mux's output on every accepted instruction, and it produces pc_plus4, which feeds pc_mux's pc_next input.

Parameters:
AddrWidth, 32, PC / instruction-memory address width
DataWidth, 32, instruction word width
ResetAddr, 0, PC value loaded on reset

Ports:
clk  input  1  core clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
pc_in  input  AddrWidth  next PC from pc_mux out
flush  input  1  redirect: load pc_in immediately, discard in-flight fetch
pc  output  AddrWidth  current fetch PC (feeds branch adder and imem_addr)
pc_plus4  output  AddrWidth  pc + 4, feeds pc_mux pc_next
imem_req  output  1  fetch request
imem_addr  output  AddrWidth  fetch address, always equal to pc
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  read data valid (at least 1 cycle after gnt)
imem_rdata  input  DataWidth  read data
instr_valid  output  1  fetched instruction available
instr  output  DataWidth  fetched instruction
instr_pc  output  AddrWidth  PC of instr
instr_ready  input  1  decode consumes instr this cycle

Behaviour:
- Reset (async, reset=1): pc=ResetAddr, state=REQ, instr_valid=0, instr=0, instr_pc=ResetAddr. imem_req=1 from the first cycle after reset deasserts.
- pc_plus4 = pc + 4, combinational, truncated to AddrWidth; 0xFFFF_FFFC wraps to 0x0000_0000.
- imem_addr = pc at all times. imem_req=1 only in state REQ.
- States:
  - REQ: imem_req=1. On imem_gnt go to WAIT.
  - WAIT: on imem_rvalid capture instr=imem_rdata and instr_pc=pc, set instr_valid=1, go to VALID.
  - VALID: instr_valid=1, output stable. On instr_ready: pc<=pc_in, instr_valid<=0, go to REQ.
  - DROP: waiting for the response of a flushed request. On imem_rvalid discard the data and go to REQ.
- Latency at zero wait states: gnt in REQ cycle t, rvalid at t+1, instr_valid at t+2. A consume at t+2 gives a new req at t+3, so throughput is 1 instr per 3 cycles.
- flush=1, pc<=pc_in at that edge, and flush takes priority over instr_ready. Per state:
  - REQ without gnt: stay in REQ, new address next cycle.
  - REQ with gnt: go to DROP.
  - WAIT without rvalid: go to DROP.
  - WAIT with rvalid in the same cycle: discard the data, go to REQ.
  - VALID: instr_valid<=0, go to REQ.
  - DROP: stay in DROP.
- Only one request outstanding; imem_req is never asserted in WAIT or DROP.
- imem_rvalid in REQ or VALID is a protocol violation: ignored, and covered by an assertion.
- instr, instr_pc and instr_valid are registered and must not change while instr_valid=1 && instr_ready=0.
- pc_in[1:0] is not checked; misalignment is handled by decode/trap logic.

Decomposition:
- New shared package fetch_pkg with fetch_state_t, a 2-bit enum: REQ, WAIT, VALID, DROP.
- pc_mux_t stays in decoder_pkg; pc_fetch does not need it.
- No sub-module. pc_mux stays instantiated beside pc_fetch in the core top level, wired pc_plus4 -> pc_next and out -> pc_in.

Test Plan:
- Reset release, ResetAddr=0, gnt same cycle, rvalid next cycle, rdata=0x00000013 -> instr_valid at cycle 2, instr=0x00000013, instr_pc=0; pc_plus4=4 throughout.
- Sequential: ready held 1, pc_in=pc_plus4, 4 fetches -> instr_pc 0,4,8,12 on 4 valid cycles, 3 cycles apart.
- Backpressure: ready=0 for 5 cycles in VALID -> instr/instr_pc stable, imem_req=0; ready=1 -> pc<=pc_in=0x100, req at 0x100 next cycle.
- Wait states: gnt delayed 3 cycles, rvalid 2 cycles after gnt -> imem_addr constant and req held until gnt, single valid instr.
- Flush in WAIT with pc_in=0x200 -> the next rvalid (old data 0xDEADBEEF) is dropped with no instr_valid, then req at 0x200 and its data is delivered.
- Wrap and async reset: pc=0xFFFFFFFC gives pc_plus4=0; reset asserted mid-WAIT -> immediately pc=ResetAddr, instr_valid=0, state REQ.
